// File: rtl/sipo_matrix_loader.sv
// Serial-in, parallel-out loader: assembles matrix A (MxK) then B (KxN) from a 32-bit word stream.
// Optional build macro SIPO_CLEAR_ON_START_EN: a legal start zeroes both arrays.
module sipo_matrix_loader #(
    parameter int MAX_M = 100,
    parameter int MAX_K = 100,
    parameter int MAX_N = 100,
    localparam int TOTAL_A = MAX_M * MAX_K,
    localparam int TOTAL_B = MAX_K * MAX_N,
    localparam int DW_M = $clog2(MAX_M + 1),
    localparam int DW_K = $clog2(MAX_K + 1),
    localparam int DW_N = $clog2(MAX_N + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW_M-1:0] cfg_m,
    input  logic [DW_K-1:0] cfg_k,
    input  logic [DW_N-1:0] cfg_n,
    input  logic [31:0]     serial_in,
    input  logic            serial_valid,
    output logic [31:0]     matrix_A [0:TOTAL_A-1],
    output logic [31:0]     matrix_B [0:TOTAL_B-1],
    output logic            active,
    output logic            phase,
    output logic            done,
    output logic            err,
    output logic [1:0]      dbg_state_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_A = 2'd1;
    localparam logic [1:0] S_LOAD_B = 2'd2;

    localparam int CW_MK = (DW_M > DW_K) ? DW_M : DW_K;
    localparam int CW    = (CW_MK > DW_N) ? CW_MK : DW_N;
    localparam int IW_A  = (TOTAL_A > 1) ? $clog2(TOTAL_A) : 1;
    localparam int IW_B  = (TOTAL_B > 1) ? $clog2(TOTAL_B) : 1;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   row_q, row_d, col_q, col_d;
    logic [DW_M-1:0] m_m_q, m_m_d;
    logic [DW_K-1:0] m_k_q, m_k_d;
    logic [DW_N-1:0] m_n_q, m_n_d;
    logic            done_q, done_d, err_q, err_d;
    logic            we_a, we_b, clr, cfg_ok;
    logic            col_last, row_last;
    logic [IW_A-1:0] idx_a;
    logic [IW_B-1:0] idx_b;
    logic [31:0]     mat_a_q [0:TOTAL_A-1];
    logic [31:0]     mat_b_q [0:TOTAL_B-1];

    assign cfg_ok = (cfg_m != '0) && (cfg_m <= DW_M'(MAX_M)) &&
                    (cfg_k != '0) && (cfg_k <= DW_K'(MAX_K)) &&
                    (cfg_n != '0) && (cfg_n <= DW_N'(MAX_N));

`ifdef SIPO_CLEAR_ON_START_EN
    assign clr = start & cfg_ok;
`else
    assign clr = 1'b0;
`endif

    // A is m_m rows of m_k columns; B is m_k rows of m_n columns.
    always_comb begin
        col_last = 1'b0;
        row_last = 1'b0;
        if (state_q == S_LOAD_A) begin
            col_last = (col_q == CW'(m_k_q) - CW'(1));
            row_last = (row_q == CW'(m_m_q) - CW'(1));
        end else if (state_q == S_LOAD_B) begin
            col_last = (col_q == CW'(m_n_q) - CW'(1));
            row_last = (row_q == CW'(m_k_q) - CW'(1));
        end
    end

    assign idx_a = IW_A'(row_q) * IW_A'(MAX_K) + IW_A'(col_q);
    assign idx_b = IW_B'(row_q) * IW_B'(MAX_N) + IW_B'(col_q);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        m_m_d   = m_m_q;
        m_k_d   = m_k_q;
        m_n_d   = m_n_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we_a    = 1'b0;
        we_b    = 1'b0;
        // start wins over a word presented in the same cycle; that word is dropped.
        if (start) begin
            row_d = '0;
            col_d = '0;
            if (cfg_ok) begin
                state_d = S_LOAD_A;
                m_m_d   = cfg_m;
                m_k_d   = cfg_k;
                m_n_d   = cfg_n;
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end else if (serial_valid && state_q != S_IDLE) begin
            we_a = (state_q == S_LOAD_A);
            we_b = (state_q == S_LOAD_B);
            if (!col_last) begin
                col_d = col_q + CW'(1);
            end else if (!row_last) begin
                col_d = '0;
                row_d = row_q + CW'(1);
            end else begin
                col_d = '0;
                row_d = '0;
                if (state_q == S_LOAD_A) begin
                    state_d = S_LOAD_B;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            m_m_q   <= '0;
            m_k_q   <= '0;
            m_n_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            m_m_q   <= m_m_d;
            m_k_q   <= m_k_d;
            m_n_q   <= m_n_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TOTAL_A; i++) mat_a_q[i] <= '0;
            for (int i = 0; i < TOTAL_B; i++) mat_b_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < TOTAL_A; i++) mat_a_q[i] <= '0;
            for (int i = 0; i < TOTAL_B; i++) mat_b_q[i] <= '0;
        end else begin
            if (we_a) mat_a_q[idx_a] <= serial_in;
            if (we_b) mat_b_q[idx_b] <= serial_in;
        end
    end

    assign matrix_A    = mat_a_q;
    assign matrix_B    = mat_b_q;
    assign active      = (state_q != S_IDLE);
    assign phase       = (state_q == S_LOAD_B);
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sipo_matrix_loader.sv
// Bench for sipo_matrix_loader at MAX_M=MAX_K=MAX_N=4: start-vector table plus hand-written
// restart, clear and reset sequences, with a write scoreboard and a full-array reference model.
module tb_sipo_matrix_loader;
    localparam int MX = 4;
    localparam int TOT = MX * MX;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cfg_m = '0, cfg_k = '0, cfg_n = '0;
    logic [31:0] serial_in = '0;
    logic        serial_valid = 1'b0;
    logic [31:0] matrix_A [0:TOT-1];
    logic [31:0] matrix_B [0:TOT-1];
    logic        active, phase, done, err;
    logic [1:0]  dbg_state;

    sipo_matrix_loader #(.MAX_M(MX), .MAX_K(MX), .MAX_N(MX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .serial_in(serial_in), .serial_valid(serial_valid),
        .matrix_A(matrix_A), .matrix_B(matrix_B),
        .active(active), .phase(phase), .done(done), .err(err),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_b;
        logic [3:0]  idx;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int   m, k, n;
        logic exp_err;
        bit   gap;
    } vec_t;

    exp_t        exp_q [$];
    logic [31:0] mdl_a [0:TOT-1];
    logic [31:0] mdl_b [0:TOT-1];
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < TOT; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < TOT; i++) begin
            chk($sformatf("%s A[%0d]", tag, i), matrix_A[i], mdl_a[i]);
            chk($sformatf("%s B[%0d]", tag, i), matrix_B[i], mdl_b[i]);
        end
    endtask

    task automatic idle_cycle(input logic exp_active);
        @(posedge clk); #1;
        chk("idle done", {31'b0, done}, 32'd0);
        chk("idle active", {31'b0, active}, {31'b0, exp_active});
    endtask

    task automatic do_start(input int m, input int k, input int n, input logic exp_err,
                            input logic with_word, input logic [31:0] w);
        start = 1'b1;
        cfg_m = m[2:0];
        cfg_k = k[2:0];
        cfg_n = n[2:0];
        serial_valid = with_word;
        serial_in = w;
        @(posedge clk); #1;
        start = 1'b0;
        serial_valid = 1'b0;
`ifdef SIPO_CLEAR_ON_START_EN
        if (!exp_err) model_clear();
`endif
        chk("start err", {31'b0, err}, {31'b0, exp_err});
        chk("start active", {31'b0, active}, {31'b0, !exp_err});
        chk("start phase", {31'b0, phase}, 32'd0);
        if (exp_err) begin
            @(posedge clk); #1;
            chk("err pulse width", {31'b0, err}, 32'd0);
            chk("err active", {31'b0, active}, 32'd0);
        end
    endtask

    // Drive one valid word; the expected write is queued and checked after the capturing edge.
    task automatic send(input logic [31:0] w, input logic is_b, input int idx);
        exp_t e;
        logic [31:0] act;
        serial_in = w;
        serial_valid = 1'b1;
        exp_q.push_back({is_b, idx[3:0], w});
        @(posedge clk); #1;
        serial_valid = 1'b0;
        e = exp_q.pop_front();
        act = e.is_b ? matrix_B[e.idx] : matrix_A[e.idx];
        chk($sformatf("word %s[%0d]", e.is_b ? "B" : "A", e.idx), act, e.data);
        if (e.is_b) mdl_b[e.idx] = e.data;
        else mdl_a[e.idx] = e.data;
    endtask

    task automatic load(input int m, input int k, input int n, input bit gap, input bit rnd,
                        input logic [31:0] base, input logic [31:0] step);
        int cnt, total, rows, cols;
        logic [31:0] w;
        logic last, exp_phase;
        cnt = 0;
        total = m * k + k * n;
        for (int p = 0; p < 2; p++) begin
            rows = (p == 0) ? m : k;
            cols = (p == 0) ? k : n;
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < cols; c++) begin
                    if (gap && cnt > 0) begin
                        for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_cycle(1'b1);
                    end
                    w = rnd ? $urandom : base + step * cnt;
                    send(w, p == 1, r * MX + c);
                    cnt++;
                    last = (cnt == total);
                    exp_phase = (p == 0) ? (r == rows - 1 && c == cols - 1) : !last;
                    chk("phase", {31'b0, phase}, {31'b0, exp_phase});
                    chk("done", {31'b0, done}, {31'b0, last});
                    chk("active", {31'b0, active}, {31'b0, !last});
                end
            end
        end
        @(posedge clk); #1;
        chk("done pulse width", {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 3, 2, 1'b0, 1'b0};
        vecs[1] = '{0, 1, 1, 1'b1, 1'b0};
        vecs[2] = '{1, 0, 1, 1'b1, 1'b0};
        vecs[3] = '{1, 1, 0, 1'b1, 1'b0};
        vecs[4] = '{5, 1, 1, 1'b1, 1'b0};
        vecs[5] = '{1, 5, 1, 1'b1, 1'b0};
        vecs[6] = '{1, 1, 7, 1'b1, 1'b0};
        vecs[7] = '{4, 4, 4, 1'b0, 1'b1};
        vecs[8] = '{1, 1, 1, 1'b0, 1'b0};

        model_clear();
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset active", {31'b0, active}, 32'd0);
        chk("reset phase", {31'b0, phase}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset err", {31'b0, err}, 32'd0);
        compare_all("reset");

        // Reference load: words 1..12 back-to-back, then the same with gaps.
        do_start(2, 3, 2, 1'b0, 1'b0, '0);
        load(2, 3, 2, 1'b0, 1'b0, 32'd1, 32'd1);
        chk("ref A[4]", matrix_A[4], 32'd4);
        chk("ref B[9]", matrix_B[9], 32'd12);
        compare_all("ref");
        do_start(2, 3, 2, 1'b0, 1'b0, '0);
        load(2, 3, 2, 1'b1, 1'b0, 32'd1, 32'd1);
        compare_all("gapped");

        // Illegal starts must not disturb the arrays.
        do_start(1, 0, 1, 1'b1, 1'b0, '0);
        do_start(5, 1, 1, 1'b1, 1'b0, '0);
        compare_all("illegal");

        for (int i = 0; i < 9; i++) begin
            do_start(vecs[i].m, vecs[i].k, vecs[i].n, vecs[i].exp_err, 1'b0, '0);
            if (!vecs[i].exp_err) load(vecs[i].m, vecs[i].k, vecs[i].n, vecs[i].gap, 1'b1, '0, '0);
            compare_all($sformatf("vec%0d", i));
        end

        // Restart during LOAD_B with a word on the start cycle; that word must be dropped.
        do_start(2, 2, 2, 1'b0, 1'b0, '0);
        send(32'hA0, 1'b0, 0);
        send(32'hA1, 1'b0, 1);
        send(32'hA2, 1'b0, 4);
        send(32'hA3, 1'b0, 5);
        chk("pre-restart phase", {31'b0, phase}, 32'd1);
        send(32'hB0, 1'b1, 0);
        do_start(1, 1, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        load(1, 1, 1, 1'b0, 1'b0, 32'h111, 32'h111);
        chk("restart A[0]", matrix_A[0], 32'h111);
        chk("restart B[0]", matrix_B[0], 32'h222);
        compare_all("restart");

        // Padding behaviour of a small load following a larger one.
        do_start(2, 2, 2, 1'b0, 1'b0, '0);
        load(2, 2, 2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
        do_start(1, 1, 1, 1'b0, 1'b0, '0);
        load(1, 1, 1, 1'b0, 1'b0, 32'd5, 32'd0);
        chk("pad A[0]", matrix_A[0], 32'd5);
`ifdef SIPO_CLEAR_ON_START_EN
        chk("pad A[1]", matrix_A[1], 32'd0);
`else
        chk("pad A[1]", matrix_A[1], 32'hFFFF_FFFF);
`endif
        compare_all("pad");

        // Asynchronous reset in the middle of LOAD_A.
        do_start(3, 3, 3, 1'b0, 1'b0, '0);
        send(32'h55, 1'b0, 0);
        send(32'h66, 1'b0, 1);
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        chk("async rst active", {31'b0, active}, 32'd0);
        chk("async rst phase", {31'b0, phase}, 32'd0);
        compare_all("async rst");
        #13 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serial_in = $urandom;
            serial_valid = 1'b1;
            @(posedge clk); #1;
            chk("no-start active", {31'b0, active}, 32'd0);
        end
        serial_valid = 1'b0;
        compare_all("no-start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
